// File: rtl/mem_data_ctrl_pkg.sv
// Shared defaults, FSM encoding and parity helper for the RiSC-16 data memory controller.
// Optional parity storage is enabled by defining MEM_DATA_PARITY_EN.
package mem_data_ctrl_pkg;

  localparam int WORD_LEN_DEF = 16;
  localparam int ADDR_LEN_DEF = 8;
  localparam int READ_LAT_DEF = 1;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_t;

  // even parity bit of one byte
  function automatic logic par8(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/mem_data_array.sv
// Single-port byte-enabled storage: synchronous write, combinational read.
// With MEM_DATA_PARITY_EN defined, a per-byte even-parity bit is stored alongside the data.
module mem_data_array
  import mem_data_ctrl_pkg::*;
#(
  parameter int WORD_LEN = WORD_LEN_DEF,
  parameter int ADDR_LEN = ADDR_LEN_DEF
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_LEN-1:0]   addr,
  input  logic [WORD_LEN-1:0]   wdata,
  input  logic [WORD_LEN/8-1:0] be,
  input  logic                  par_flip,
  output logic [WORD_LEN-1:0]   rdata,
  output logic                  rerr
);

  localparam int NB    = WORD_LEN / 8;
  localparam int DEPTH = 1 << ADDR_LEN;

  logic [NB-1:0][7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NB; i++)
        if (be[i]) mem[addr][i] <= wdata[8*i +: 8];
    end
  end

  assign rdata = mem[addr];

`ifdef MEM_DATA_PARITY_EN
  logic [NB-1:0] par [DEPTH];
  logic [NB-1:0] par_calc;

  // par_flip deliberately stores the wrong parity so the error path can be exercised
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NB; i++)
        if (be[i]) par[addr][i] <= par8(wdata[8*i +: 8]) ^ par_flip;
    end
  end

  always_comb begin
    par_calc = '0;
    for (int i = 0; i < NB; i++) par_calc[i] = par8(mem[addr][i]);
  end

  assign rerr = |(par_calc ^ par[addr]);
`else
  logic unused_par;
  assign unused_par = par_flip;
  assign rerr       = 1'b0;
`endif

endmodule

// File: rtl/mem_data_ctrl.sv
// Data memory controller: post-reset clear sequencer, valid/ready request port and
// READ_LAT-deep response pipeline. Parity checking follows MEM_DATA_PARITY_EN.
module mem_data_ctrl
  import mem_data_ctrl_pkg::*;
#(
  parameter int WORD_LEN = WORD_LEN_DEF,
  parameter int ADDR_LEN = ADDR_LEN_DEF,
  parameter int READ_LAT = READ_LAT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_LEN-1:0]   req_addr,
  input  logic [WORD_LEN-1:0]   req_wdata,
  input  logic [WORD_LEN/8-1:0] req_be,
  input  logic                  par_inj,
  output logic                  rsp_valid,
  output logic [WORD_LEN-1:0]   rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy
);

  localparam int NB    = WORD_LEN / 8;
  localparam int DEPTH = 1 << ADDR_LEN;
  localparam logic [ADDR_LEN:0] LAST = (ADDR_LEN+1)'(DEPTH - 1);

  typedef struct packed {
    logic                err;
    logic [WORD_LEN-1:0] data;
  } rsp_t;

  state_t              state;
  logic [ADDR_LEN:0]   cnt;
  logic                acc, rd_acc;
  logic                mem_we, mem_flip, mem_rerr;
  logic [ADDR_LEN-1:0] mem_addr;
  logic [WORD_LEN-1:0] mem_wdata, mem_rdata;
  logic [NB-1:0]       mem_be;

  logic [READ_LAT:1]   vld_pipe;
  rsp_t [READ_LAT:1]   rsp_pipe;

  // gating with rst keeps a stale req_ready from writing memory on a reset edge
  assign acc    = rst & req_valid & req_ready;
  assign rd_acc = acc & ~req_write;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_CLEAR;
      cnt       <= '0;
      req_ready <= 1'b0;
      busy      <= 1'b1;
    end else begin
      case (state)
        S_CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state     <= S_READY;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_we    = (rst & (state == S_CLEAR)) | (acc & req_write);
    mem_addr  = req_addr;
    mem_wdata = req_wdata;
    mem_be    = req_be;
    mem_flip  = par_inj;
    if (state == S_CLEAR) begin
      mem_addr  = cnt[ADDR_LEN-1:0];
      mem_wdata = '0;
      mem_be    = '1;
      mem_flip  = 1'b0;
    end
  end

  mem_data_array #(
    .WORD_LEN (WORD_LEN),
    .ADDR_LEN (ADDR_LEN)
  ) u_array (
    .clk      (clk),
    .we       (mem_we),
    .addr     (mem_addr),
    .wdata    (mem_wdata),
    .be       (mem_be),
    .par_flip (mem_flip),
    .rdata    (mem_rdata),
    .rerr     (mem_rerr)
  );

  // stages load only with a valid beat, so the last stage holds data between responses
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_pipe <= '0;
      rsp_pipe <= '0;
    end else begin
      vld_pipe[1] <= rd_acc;
      if (rd_acc) rsp_pipe[1] <= {mem_rerr, mem_rdata};
      for (int s = 2; s <= READ_LAT; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        if (vld_pipe[s-1]) rsp_pipe[s] <= rsp_pipe[s-1];
      end
    end
  end

  assign rsp_valid = vld_pipe[READ_LAT];
  assign rsp_rdata = rsp_pipe[READ_LAT].data;
  assign rsp_err   = rsp_pipe[READ_LAT].err;

endmodule

// File: tb/tb_mem_data_ctrl.sv
// Directed bench for mem_data_ctrl (ADDR_LEN=4, WORD_LEN=16, READ_LAT=2): vector table plus
// hand-written reset sequences; responses are checked against an in-order expectation queue.
module tb_mem_data_ctrl;

  localparam int WL = 16, AL = 4, RL = 2, DEPTH = 16;
`ifdef MEM_DATA_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic          clk = 1'b0, rst = 1'b0;
  logic          req_valid = 1'b0, req_write = 1'b0, par_inj = 1'b0;
  logic [AL-1:0] req_addr = '0;
  logic [WL-1:0] req_wdata = '0;
  logic [1:0]    req_be = '0;
  logic          req_ready, rsp_valid, rsp_err, busy;
  logic [WL-1:0] rsp_rdata;

  int tests = 0, fails = 0, cyc = 0;

  always #5 clk = ~clk;

  mem_data_ctrl #(.WORD_LEN(WL), .ADDR_LEN(AL), .READ_LAT(RL)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .par_inj(par_inj), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy(busy)
  );

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic        inj;
    logic [15:0] edata;
    logic        eerr;
  } vec_t;

  vec_t        vt[$];
  logic [15:0] exp_d[$];
  logic        exp_e[$];
  int          exp_c[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // advance one edge, sample 1 ns later and score any response
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (rsp_valid) begin
      if (exp_d.size() == 0) check("unexpected rsp_valid", 1, 0);
      else begin
        check("rsp cycle", cyc, exp_c.pop_front());
        check("rsp_rdata", rsp_rdata, exp_d.pop_front());
        check("rsp_err", rsp_err, exp_e.pop_front());
      end
    end
  endtask

  task automatic wait_ready(input string name);
    int k = 0;
    bit bad = 0;
    while (!req_ready && k < 100) begin
      if (!busy) bad = 1;
      tick();
      k++;
    end
    check({name, " clear cycles"}, k, DEPTH);
    check({name, " busy low during clear"}, bad, 0);
    check({name, " busy after clear"}, busy, 0);
  endtask

  task automatic apply(input vec_t v);
    req_valid = 1'b1; req_write = v.wr; req_addr = v.addr;
    req_wdata = v.wdata; req_be = v.be; par_inj = v.inj;
    if (!v.wr) begin
      exp_d.push_back(v.edata);
      exp_e.push_back(v.eerr);
      exp_c.push_back(cyc + RL);
    end
    tick();
    req_valid = 1'b0; req_write = 1'b0; par_inj = 1'b0;
  endtask

  function automatic vec_t mk_wr(input int a, input logic [15:0] d, input logic [1:0] be,
                                 input logic inj);
    vec_t v;
    v.wr = 1'b1; v.addr = a[3:0]; v.wdata = d; v.be = be; v.inj = inj;
    v.edata = '0; v.eerr = 1'b0;
    return v;
  endfunction

  function automatic vec_t mk_rd(input int a, input logic [15:0] d, input logic e);
    vec_t v;
    v.wr = 1'b0; v.addr = a[3:0]; v.wdata = '0; v.be = '0; v.inj = 1'b0;
    v.edata = d; v.eerr = e;
    return v;
  endfunction

  task automatic drain();
    repeat (RL + 2) tick();
    check("pending responses", exp_d.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < DEPTH; a++) vt.push_back(mk_rd(a, 16'h0000, 1'b0));
    for (int i = 0; i < 8; i++) vt.push_back(mk_wr(2*i, 16'(i*i + 10), 2'b11, 1'b0));
    for (int i = 0; i < 8; i++) vt.push_back(mk_rd(2*i, 16'(i*i + 10), 1'b0));
    vt.push_back(mk_wr(3, 16'hABCD, 2'b11, 1'b0));
    vt.push_back(mk_wr(3, 16'h1234, 2'b01, 1'b0));
    vt.push_back(mk_rd(3, 16'hAB34, 1'b0));
    vt.push_back(mk_wr(3, 16'hFFFF, 2'b00, 1'b0));
    vt.push_back(mk_rd(3, 16'hAB34, 1'b0));
    vt.push_back(mk_wr(3, 16'h5600, 2'b10, 1'b0));
    vt.push_back(mk_rd(3, 16'h5634, 1'b0));
    vt.push_back(mk_wr(15, 16'hC0DE, 2'b11, 1'b0));
    vt.push_back(mk_rd(15, 16'hC0DE, 1'b0));
    vt.push_back(mk_rd(0, 16'h000A, 1'b0));
    vt.push_back(mk_wr(9, 16'hBEEF, 2'b11, 1'b0));
    vt.push_back(mk_rd(9, 16'hBEEF, 1'b0));
    vt.push_back(mk_wr(7, 16'h5A5A, 2'b11, 1'b1));
    vt.push_back(mk_rd(7, 16'h5A5A, PAR));
    vt.push_back(mk_wr(7, 16'h5A5A, 2'b11, 1'b0));
    vt.push_back(mk_rd(7, 16'h5A5A, 1'b0));

    // power-on reset and full clear
    rst = 1'b0;
    repeat (3) tick();
    check("reset req_ready", req_ready, 0);
    check("reset busy", busy, 1);
    check("reset rsp_valid", rsp_valid, 0);
    check("reset rsp_rdata", rsp_rdata, 0);
    check("reset rsp_err", rsp_err, 0);
    rst = 1'b1;
    wait_ready("reset");

    foreach (vt[i]) apply(vt[i]);
    drain();

    // reset five cycles into the clear restarts it from scratch
    rst = 1'b0;
    tick();
    rst = 1'b1;
    repeat (5) tick();
    check("mid-clear busy", busy, 1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    wait_ready("mid-clear");

    // read accepted, then reset: its response must be dropped
    req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd3;
    tick();
    req_valid = 1'b0;
    rst = 1'b0;
    tick();
    check("mid-read rsp_valid", rsp_valid, 0);
    tick();
    check("mid-read rsp_valid held", rsp_valid, 0);
    rst = 1'b1;
    wait_ready("mid-read");
    apply(mk_rd(3, 16'h0000, 1'b0));
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
